// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Single-clock parametrised FIFO with an occupancy count, programmable
//   almost-full / almost-empty thresholds and a registered read port that
//   emits a one-cycle rvalid strobe per popped word.
//
// Parameters
//   WIDTH   data width in bits (>=1)
//   DEPTH   number of entries, power of two, >=4
//   AF_LVL  walmost_full when count >= AF_LVL (1..DEPTH)
//   AE_LVL  ralmost_empty when count <= AE_LVL (0..DEPTH-1)
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   winc, wdata     write request and data
//   wfull           FIFO holds DEPTH entries
//   walmost_full    count >= AF_LVL
//   rinc            read request
//   rdata, rvalid   popped word and its one-cycle strobe
//   rempty          FIFO holds no entries
//   ralmost_empty   count <= AE_LVL
//   count           occupancy 0..DEPTH
//   overflow        sticky: write attempted while full
//   underflow       sticky: read attempted while empty
//
// Handshake: a write is accepted at a clock edge when winc=1 and the
// registered wfull=0; a read is accepted when rinc=1 and the registered
// rempty=0. Rejected requests have no effect on state. Each accepted read
// produces exactly one cycle with rvalid=1 and rdata holding the popped
// word, starting at the edge that accepted it. rdata holds its value when
// rvalid=0.
//
// Build option
//   SYNC_FIFO_ERR_EN  when defined, overflow/underflow are sticky error
//                     flags cleared only by rst; otherwise they are tied 0.

module sync_fifo_param #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 64,
  parameter int AF_LVL = DEPTH - 4,
  parameter int AE_LVL = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       winc,
  input  logic [WIDTH-1:0]           wdata,
  output logic                       wfull,
  output logic                       walmost_full,
  input  logic                       rinc,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  output logic                       rempty,
  output logic                       ralmost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra bit so they wrap naturally at 2*DEPTH; only
  // the low AW bits address the storage.
  logic [CW-1:0] wptr;
  logic [CW-1:0] rptr;
  logic [CW-1:0] count_nxt;

  logic wr_acc;
  logic rd_acc;

  // Acceptance uses the registered flags, so a same-cycle pop never frees
  // room for a write into a full FIFO, and a same-cycle push never makes
  // an empty FIFO readable.
  assign wr_acc = winc & ~wfull;
  assign rd_acc = rinc & ~rempty;

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - 1'b1;
    end
  end

  // Storage is not reset; stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      wfull         <= 1'b0;
      walmost_full  <= 1'b0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rdata         <= '0;
      rvalid        <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rdata <= mem[rptr[AW-1:0]];
        rptr  <= rptr + 1'b1;
      end
      rvalid        <= rd_acc;
      count         <= count_nxt;
      wfull         <= (count_nxt == DEPTH_C);
      rempty        <= (count_nxt == '0);
      walmost_full  <= (count_nxt >= AF_C);
      ralmost_empty <= (count_nxt <= AE_C);
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  // Sticky error flags: set on a request made against a full/empty FIFO,
  // held until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull) begin
        overflow <= 1'b1;
      end
      if (rinc && rempty) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (WIDTH=8, DEPTH=64, AF_LVL=60, AE_LVL=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each step() shows the result of exactly one edge.

module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;

`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             winc;
  logic [WIDTH-1:0] wdata;
  logic             wfull;
  logic             walmost_full;
  logic             rinc;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             rempty;
  logic             ralmost_empty;
  logic [6:0]       count;
  logic             overflow;
  logic             underflow;

  int tests_run;
  int tests_failed;

  sync_fifo_param #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AF_LVL(60),
    .AE_LVL(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .wdata        (wdata),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .rinc         (rinc),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .rempty       (rempty),
    .ralmost_empty(ralmost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    winc = 1'b0;
    rinc = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // driver: one accepted write per call into a non-full FIFO
  task automatic push(input logic [WIDTH-1:0] d);
    winc  = 1'b1;
    wdata = d;
    step();
    winc  = 1'b0;
  endtask

  task automatic test_reset();
    wdata = '0;
    do_reset();
    step();
    tests_run++;
    if ({rempty, ralmost_empty, wfull, walmost_full, rvalid} !== 5'b11000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b exp 11000", {rempty, ralmost_empty, wfull, walmost_full, rvalid});
    end
    tests_run++;
    if (count !== 7'd0 || rdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_count_rdata: got count=%0d rdata=%h exp 0/00", count, rdata);
    end
    tests_run++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_err: got ovf=%b unf=%b exp 0/0", overflow, underflow);
    end
  endtask

  task automatic test_fill_drain();
    logic [WIDTH-1:0] exp_d;
    for (int i = 1; i <= DEPTH; i++) begin
      push(8'(i));
      tests_run++;
      if (count !== 7'(i) || walmost_full !== (i >= 60) || wfull !== (i == DEPTH) || rempty !== 1'b0) begin
        tests_failed++;
        $display("FAIL fill_%0d: got count=%0d af=%b full=%b empty=%b exp %0d/%b/%b/0",
                 i, count, walmost_full, wfull, rempty, i, (i >= 60), (i == DEPTH));
      end
    end
    rinc = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      exp_d = 8'(k);
      tests_run++;
      if (rvalid !== 1'b1 || rdata !== exp_d || count !== 7'(DEPTH - k) ||
          ralmost_empty !== ((DEPTH - k) <= 4)) begin
        tests_failed++;
        $display("FAIL drain_%0d: got rv=%b rdata=%h count=%0d ae=%b exp 1/%h/%0d/%b",
                 k, rvalid, rdata, count, ralmost_empty, exp_d, DEPTH - k, ((DEPTH - k) <= 4));
      end
    end
    tests_run++;
    if (rempty !== 1'b1 || wfull !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_empty: got empty=%b full=%b exp 1/0", rempty, wfull);
    end
    step();
    rinc = 1'b0;
    tests_run++;
    if (rvalid !== 1'b0 || rdata !== 8'h40) begin
      tests_failed++;
      $display("FAIL drain_idle: got rv=%b rdata=%h exp 0/40", rvalid, rdata);
    end
  endtask

  // 10 words resident, then 200 simultaneous push/pop cycles: enough for
  // both 7-bit pointers to wrap past 127 twice.
  task automatic test_simul();
    logic [WIDTH-1:0] wr_val;
    logic [WIDTH-1:0] rd_val;
    wr_val = 8'h10;
    rd_val = 8'h10;
    for (int i = 0; i < 10; i++) begin
      push(wr_val);
      wr_val++;
    end
    winc = 1'b1;
    rinc = 1'b1;
    for (int c = 0; c < 200; c++) begin
      wdata = wr_val;
      step();
      wr_val++;
      tests_run++;
      if (count !== 7'd10 || rvalid !== 1'b1 || rdata !== rd_val) begin
        tests_failed++;
        $display("FAIL simul_%0d: got count=%0d rv=%b rdata=%h exp 10/1/%h", c, count, rvalid, rdata, rd_val);
      end
      rd_val++;
    end
    winc = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      tests_run++;
      if (rvalid !== 1'b1 || rdata !== rd_val) begin
        tests_failed++;
        $display("FAIL simul_tail_%0d: got rv=%b rdata=%h exp 1/%h", k, rvalid, rdata, rd_val);
      end
      rd_val++;
    end
    rinc = 1'b0;
    step();
    tests_run++;
    if (count !== 7'd0 || rempty !== 1'b1 || rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_end: got count=%0d empty=%b rv=%b exp 0/1/0", count, rempty, rvalid);
    end
  endtask

  task automatic test_full_empty_simul();
    logic [WIDTH-1:0] rd_val;
    for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i));
    // full: read accepted, write of 0xEE rejected
    winc  = 1'b1;
    rinc  = 1'b1;
    wdata = 8'hEE;
    step();
    winc = 1'b0;
    tests_run++;
    if (count !== 7'd63 || wfull !== 1'b0 || rvalid !== 1'b1 || rdata !== 8'h80) begin
      tests_failed++;
      $display("FAIL full_simul: got count=%0d full=%b rv=%b rdata=%h exp 63/0/1/80", count, wfull, rvalid, rdata);
    end
    rd_val = 8'h81;
    for (int k = 0; k < 63; k++) begin
      step();
      tests_run++;
      if (rvalid !== 1'b1 || rdata !== rd_val) begin
        tests_failed++;
        $display("FAIL full_drain_%0d: got rv=%b rdata=%h exp 1/%h", k, rvalid, rdata, rd_val);
      end
      rd_val++;
    end
    // empty: write of 0x77 accepted, read rejected
    winc  = 1'b1;
    wdata = 8'h77;
    step();
    winc = 1'b0;
    rinc = 1'b0;
    tests_run++;
    if (count !== 7'd1 || rvalid !== 1'b0 || rempty !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_simul: got count=%0d rv=%b empty=%b exp 1/0/0", count, rvalid, rempty);
    end
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    tests_run++;
    if (rvalid !== 1'b1 || rdata !== 8'h77 || count !== 7'd0) begin
      tests_failed++;
      $display("FAIL empty_simul_read: got rv=%b rdata=%h count=%0d exp 1/77/0", rvalid, rdata, count);
    end
  endtask

  task automatic test_errors();
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    winc  = 1'b1;
    wdata = 8'hEE;
    step();
    winc = 1'b0;
    tests_run++;
    if (overflow !== ERR_EN || count !== 7'd64 || underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_set: got ovf=%b count=%0d unf=%b exp %b/64/0", overflow, count, underflow, ERR_EN);
    end
    rinc = 1'b1;
    for (int k = 0; k < DEPTH; k++) step();
    rinc = 1'b0;
    tests_run++;
    if (overflow !== ERR_EN || count !== 7'd0 || rdata !== 8'h3F) begin
      tests_failed++;
      $display("FAIL overflow_sticky: got ovf=%b count=%0d rdata=%h exp %b/0/3f", overflow, count, rdata, ERR_EN);
    end
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    tests_run++;
    if (underflow !== ERR_EN || rvalid !== 1'b0 || count !== 7'd0) begin
      tests_failed++;
      $display("FAIL underflow_set: got unf=%b rv=%b count=%0d exp %b/0/0", underflow, rvalid, count, ERR_EN);
    end
    do_reset();
    tests_run++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clear: got ovf=%b unf=%b exp 0/0", overflow, underflow);
    end
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    rinc = 1'b1;
    rst  = 1'b1;
    step();
    rst  = 1'b0;
    rinc = 1'b0;
    tests_run++;
    if (count !== 7'd0 || rempty !== 1'b1 || rvalid !== 1'b0 || rdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_mid_read: got count=%0d empty=%b rv=%b rdata=%h exp 0/1/0/00", count, rempty, rvalid, rdata);
    end
    push(8'hA5);
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    tests_run++;
    if (rvalid !== 1'b1 || rdata !== 8'hA5 || count !== 7'd0) begin
      tests_failed++;
      $display("FAIL rst_readback: got rv=%b rdata=%h count=%0d exp 1/a5/0", rvalid, rdata, count);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = '0;
    test_reset();
    test_fill_drain();
    test_simul();
    test_full_empty_simul();
    test_errors();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
